// File: rtl/alu_iter.sv
// alu_iter: registered execute-stage ALU with iterative unsigned multiply/divide.
//
// Single-cycle ops (add/sub/logic/shift/pass) load the output registers on the
// accepting edge. MULU and DIVU with a non-zero divisor take WIDTH iterations
// in the ITER state: shift-add multiply, and restoring division with a WIDTH+1
// bit partial remainder. DIVU by zero finishes in one cycle.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   flush                   abort the in-flight op / drop an accept this cycle
//   in_valid, in_ready      input handshake (in_ready high only in IDLE)
//   op[3:0], a, b, cfin     operation, operands, carry-in
//   out_valid               one-cycle pulse when the outputs below are new
//   result, result_hi       primary result, high product / remainder
//   cfout, zf, sf, dz       carry/borrow, zero, sign, divide-by-zero flags
//   busy                    multi-cycle op in flight
module alu_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cfin,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cfout,
    output logic             zf,
    output logic             sf,
    output logic             dz,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADDC  = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_SUBC  = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd7;
    localparam logic [3:0] OP_SHR   = 4'd8;
    localparam logic [3:0] OP_SAL   = 4'd9;
    localparam logic [3:0] OP_SAR   = 4'd10;
    localparam logic [3:0] OP_PASSB = 4'd11;
    localparam logic [3:0] OP_MULU  = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;

    typedef enum logic {IDLE, ITER} state_t;

    state_t state_reg, state_next;

    // Iteration registers. hi_reg is the partial remainder for DIVU (WIDTH+1
    // bits) and the running high product for MULU (bit WIDTH unused there).
    logic             is_div_reg;
    logic [WIDTH:0]   hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic [SHW-1:0]   count_reg;

    // Output registers
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_hi_reg;
    logic             cfout_reg;
    logic             dz_reg;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [SHW-1:0]   sh;
    logic             add_cin;
    logic             sub_bin;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH:0]   shl_full;
    logic [WIDTH:0]   shr_full;
    logic [WIDTH:0]   sar_full;
    logic signed [WIDTH:0] sar_src;
    logic [WIDTH-1:0] sc_r;
    logic [WIDTH-1:0] sc_rh;
    logic             sc_cf;
    logic             sc_dz;
    logic             is_multi;

    assign sh       = b[SHW-1:0];
    assign add_cin  = (op == OP_ADDC) & cfin;
    assign sub_bin  = (op == OP_SUBC) & cfin;
    assign add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
    assign sub_full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_bin};
    // Left shift: bit WIDTH holds the last bit shifted out.
    assign shl_full = {1'b0, a} << sh;
    // Right shifts: a guard bit below the LSB catches the last bit shifted out.
    assign shr_full = {a, 1'b0} >> sh;
    assign sar_src  = {a, 1'b0};
    assign sar_full = sar_src >>> sh;

    assign is_multi = (op == OP_MULU) || ((op == OP_DIVU) && (b != '0));

    always_comb begin
        sc_r  = a;
        sc_rh = '0;
        sc_cf = cfin;
        sc_dz = 1'b0;
        case (op)
            OP_ADD, OP_ADDC: begin
                sc_r  = add_full[WIDTH-1:0];
                sc_cf = add_full[WIDTH];
            end
            OP_SUB, OP_SUBC: begin
                sc_r  = sub_full[WIDTH-1:0];
                sc_cf = sub_full[WIDTH];
            end
            OP_AND: begin sc_r = a & b; sc_cf = 1'b0; end
            OP_OR:  begin sc_r = a | b; sc_cf = 1'b0; end
            OP_XOR: begin sc_r = a ^ b; sc_cf = 1'b0; end
            OP_SHL, OP_SAL: begin
                sc_r  = shl_full[WIDTH-1:0];
                sc_cf = (sh == '0) ? cfin : shl_full[WIDTH];
            end
            OP_SHR: begin
                sc_r  = shr_full[WIDTH:1];
                sc_cf = (sh == '0) ? cfin : shr_full[0];
            end
            OP_SAR: begin
                sc_r  = sar_full[WIDTH:1];
                sc_cf = (sh == '0) ? cfin : sar_full[0];
            end
            OP_PASSB: sc_r = b;
            OP_DIVU: begin
                // Only reached here with b == 0.
                sc_r  = '1;
                sc_rh = a;
                sc_cf = 1'b0;
                sc_dz = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH:0]   iter_hi_next;
    logic [WIDTH-1:0] iter_lo_next;

    assign mul_sum   = lo_reg[0] ? ({1'b0, hi_reg[WIDTH-1:0]} + {1'b0, opnd_reg})
                                 : {1'b0, hi_reg[WIDTH-1:0]};
    assign div_shift = {hi_reg[WIDTH-1:0], lo_reg[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_reg};

    always_comb begin
        if (is_div_reg) begin
            iter_hi_next = div_ge ? (div_shift - {1'b0, opnd_reg}) : div_shift;
            iter_lo_next = {lo_reg[WIDTH-2:0], div_ge};
        end else begin
            // Product shifts right one place per step; the multiplier drains
            // out of lo_reg as product bits fill in from the top.
            iter_hi_next = {1'b0, mul_sum[WIDTH:1]};
            iter_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic accept;
    logic last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last       = 1'b0;
        in_ready   = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept = 1'b1;
                    if (is_multi) state_next = ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (flush) begin
                    state_next = IDLE;
                end else if (count_reg == SHW'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output load mux: a single-cycle accept or the final iteration.
    logic             ld_en;
    logic [WIDTH-1:0] ld_r;
    logic [WIDTH-1:0] ld_rh;
    logic             ld_cf;
    logic             ld_dz;

    always_comb begin
        ld_en = (accept && !is_multi) || last;
        ld_r  = sc_r;
        ld_rh = sc_rh;
        ld_cf = sc_cf;
        ld_dz = sc_dz;
        if (last) begin
            ld_r  = iter_lo_next;
            ld_rh = iter_hi_next[WIDTH-1:0];
            ld_cf = is_div_reg ? 1'b0 : (iter_hi_next[WIDTH-1:0] != '0);
            ld_dz = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div_reg    <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            opnd_reg      <= '0;
            count_reg     <= '0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            result_hi_reg <= '0;
            cfout_reg     <= 1'b0;
            dz_reg        <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            if (accept && is_multi) begin
                is_div_reg <= (op == OP_DIVU);
                hi_reg     <= '0;
                count_reg  <= '0;
                if (op == OP_DIVU) begin
                    lo_reg   <= a;
                    opnd_reg <= b;
                end else begin
                    lo_reg   <= b;
                    opnd_reg <= a;
                end
            end else if (state_reg == ITER && !flush) begin
                hi_reg    <= iter_hi_next;
                lo_reg    <= iter_lo_next;
                count_reg <= count_reg + SHW'(1);
            end
            if (ld_en) begin
                out_valid_reg <= 1'b1;
                result_reg    <= ld_r;
                result_hi_reg <= ld_rh;
                cfout_reg     <= ld_cf;
                dz_reg        <= ld_dz;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign result_hi = result_hi_reg;
    assign cfout     = cfout_reg;
    assign dz        = dz_reg;
    // Flags follow the held result, so reset gives zf = 1 and DIVU by zero
    // (result all ones) gives zf = 0, sf = 1.
    assign zf        = (result_reg == '0);
    assign sf        = result_reg[WIDTH-1];

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed cases, randomized ops against a
// behavioural model, back-to-back single-cycle ops, flush/reset aborts, and a
// WIDTH=8 instance for the narrow-width cases.
module tb_alu_iter;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cfin = 1'b0;
    logic         out_valid;
    logic [W-1:0] result, result_hi;
    logic         cfout, zf, sf, dz, busy;

    alu_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .op(op), .a(a), .b(b), .cfin(cfin),
        .out_valid(out_valid), .result(result), .result_hi(result_hi),
        .cfout(cfout), .zf(zf), .sf(sf), .dz(dz), .busy(busy)
    );

    // Narrow instance
    logic       flush8 = 1'b0;
    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [3:0] op8 = '0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cfin8 = 1'b0;
    logic       out_valid8;
    logic [7:0] result8, result_hi8;
    logic       cfout8, zf8, sf8, dz8, busy8;

    alu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .flush(flush8), .in_valid(in_valid8),
        .in_ready(in_ready8), .op(op8), .a(a8), .b(b8), .cfin(cfin8),
        .out_valid(out_valid8), .result(result8), .result_hi(result_hi8),
        .cfout(cfout8), .zf(zf8), .sf(sf8), .dz(dz8), .busy(busy8)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] rh;
        logic         cf;
        logic         dz;
    } exp_t;

    // Reference model straight from the op table, using wide integer arithmetic.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic ci);
        exp_t e;
        logic [63:0] s;
        logic [63:0] sub_amt;
        logic signed [W-1:0] xs;
        int sh;
        e  = '0;
        xs = x;
        sh = int'(y % W);
        e.cf = ci;
        e.r  = x;
        case (o)
            4'd0, 4'd1: begin
                s = 64'(x) + 64'(y) + ((o == 4'd1) ? 64'(ci) : 64'd0);
                e.r = s[W-1:0]; e.cf = s[W];
            end
            4'd2, 4'd3: begin
                sub_amt = 64'(y) + ((o == 4'd3) ? 64'(ci) : 64'd0);
                s = 64'(x) - sub_amt;
                e.r = s[W-1:0]; e.cf = (64'(x) < sub_amt);
            end
            4'd4: begin e.r = x & y; e.cf = 1'b0; end
            4'd5: begin e.r = x | y; e.cf = 1'b0; end
            4'd6: begin e.r = x ^ y; e.cf = 1'b0; end
            4'd7, 4'd9: begin
                s = 64'(x) << sh;
                e.r = s[W-1:0];
                if (sh != 0) e.cf = s[W];
            end
            4'd8: begin
                e.r = x >> sh;
                if (sh != 0) e.cf = x[sh-1];
            end
            4'd10: begin
                e.r = xs >>> sh;
                if (sh != 0) e.cf = x[sh-1];
            end
            4'd11: e.r = y;
            4'd12: begin
                s = 64'(x) * 64'(y);
                e.r = s[W-1:0]; e.rh = s[2*W-1:W]; e.cf = (e.rh != '0);
            end
            4'd13: begin
                e.cf = 1'b0;
                if (y == '0) begin
                    e.r = '1; e.rh = x; e.dz = 1'b1;
                end else begin
                    e.r = x / y; e.rh = x % y;
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic bit multi(input logic [3:0] o, input logic [W-1:0] y);
        return (o == 4'd12) || (o == 4'd13 && y != '0);
    endfunction

    // Issue one op, wait (bounded) for out_valid, check latency, busy, outputs.
    task automatic do_op(input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ci);
        exp_t e;
        int n, nbusy, lat;
        bit seen;
        e   = model(o, x, y, ci);
        lat = multi(o, y) ? W + 1 : 1;
        @(negedge clk);
        op = o; a = x; b = y; cfin = ci; in_valid = 1'b1;
        check($sformatf("op%0d.in_ready", o), 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0; nbusy = 0; seen = 0;
        while (!seen && n < W + 4) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1;
            else if (busy) nbusy++;
        end
        check($sformatf("op%0d.latency", o), 64'(n), 64'(lat));
        check($sformatf("op%0d.busy_cycles", o), 64'(nbusy), 64'(lat - 1));
        check($sformatf("op%0d.result", o), 64'(result), 64'(e.r));
        check($sformatf("op%0d.result_hi", o), 64'(result_hi), 64'(e.rh));
        check($sformatf("op%0d.cf", o), 64'(cfout), 64'(e.cf));
        check($sformatf("op%0d.zf", o), 64'(zf), 64'(e.r == '0));
        check($sformatf("op%0d.sf", o), 64'(sf), 64'(e.r[W-1]));
        check($sformatf("op%0d.dz", o), 64'(dz), 64'(e.dz));
        @(negedge clk);
        check($sformatf("op%0d.pulse", o), 64'(out_valid), 64'd0);
        $display("op=%0d a=%h b=%h cfin=%0d -> r=%h rh=%h cf=%0d dz=%0d lat=%0d",
                 o, x, y, ci, result, result_hi, cfout, dz, n);
    endtask

    initial begin
        exp_t e, prev;
        exp_t q[$];
        int n, ov;
        bit seen;
        logic [3:0] o;
        logic [W-1:0] x, y;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.result", 64'(result), 64'd0);
        check("rst.result_hi", 64'(result_hi), 64'd0);
        check("rst.cf", 64'(cfout), 64'd0);
        check("rst.zf", 64'(zf), 64'd1);
        check("rst.sf", 64'(sf), 64'd0);
        check("rst.dz", 64'(dz), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'd1);

        // Directed cases; a few results pinned to constants as well.
        do_op(4'd0, 16'hFFFF, 16'h0001, 1'b0);
        check("add.const", 64'({cfout, result}), 64'h10000);
        do_op(4'd3, 16'h0005, 16'h0005, 1'b1);
        check("subc.const", 64'({cfout, result}), 64'h1FFFF);
        do_op(4'd10, 16'h8004, 16'h0002, 1'b1);
        check("sar.const", 64'({cfout, result}), 64'h0E001);
        do_op(4'd12, 16'h1234, 16'h0100, 1'b0);
        check("mulu.const", 64'({result_hi, result}), 64'h00123400);
        do_op(4'd13, 16'd1000, 16'd7, 1'b0);
        check("divu.const", 64'({result_hi, result}), 64'h0006008E);
        do_op(4'd13, 16'h0042, 16'h0000, 1'b0);
        do_op(4'd7, 16'h8001, 16'h0000, 1'b1);  // zero shift keeps cfin
        do_op(4'd14, 16'hABCD, 16'h1111, 1'b1);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 15));
            x = W'($urandom);
            y = ($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom);
            if (o == 4'd13 && $urandom_range(0, 1) == 1) y = W'($urandom_range(1, 300));
            do_op(o, x, y, 1'($urandom));
        end

        // Back-to-back single-cycle ops
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = q.pop_front();
                check("b2b.valid", 64'(out_valid), 64'd1);
                check("b2b.result", 64'(result), 64'(e.r));
                check("b2b.cf", 64'(cfout), 64'(e.cf));
                $display("b2b %0d r=%h cf=%0d", i, result, cfout);
            end
            if (i < 9) begin
                o = 4'($urandom_range(0, 14));
                if (o == 4'd12) o = 4'd14;
                x = W'($urandom);
                y = (o == 4'd13) ? W'(0) : W'($urandom);
                op = o; a = x; b = y; cfin = 1'($urandom); in_valid = 1'b1;
                q.push_back(model(o, x, y, cfin));
            end else begin
                in_valid = 1'b0;
            end
        end

        // Flush at iteration 5 of a MULU
        do_op(4'd6, 16'h5A5A, 16'h0F0F, 1'b0);
        prev = model(4'd6, 16'h5A5A, 16'h0F0F, 1'b0);
        @(negedge clk);
        op = 4'd12; a = 16'h00FF; b = 16'h0101; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush.in_ready", 64'(in_ready), 64'd1);
        check("flush.busy", 64'(busy), 64'd0);
        ov = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (out_valid) ov++;
        end
        check("flush.no_valid", 64'(ov), 64'd0);
        check("flush.result_kept", 64'(result), 64'(prev.r));
        $display("flush mid-MULU: out_valid pulses=%0d result=%h", ov, result);

        // Flush together with in_valid in IDLE drops the op
        @(negedge clk);
        op = 4'd0; a = 16'h0001; b = 16'h0001; in_valid = 1'b1; flush = 1'b1;
        check("idleflush.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 begin in_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("idleflush.no_valid", 64'(out_valid), 64'd0);
        check("idleflush.result_kept", 64'(result), 64'(prev.r));
        $display("flush in IDLE: out_valid=%0d", out_valid);

        // Reset at iteration 5 of a DIVU
        @(negedge clk);
        op = 4'd13; a = 16'hFFFF; b = 16'h0003; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.result", 64'(result), 64'd0);
        check("midrst.result_hi", 64'(result_hi), 64'd0);
        check("midrst.zf", 64'(zf), 64'd1);
        check("midrst.sf", 64'(sf), 64'd0);
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        $display("reset mid-DIVU: result=%h zf=%0d busy=%0d", result, zf, busy);

        // WIDTH=8 instance: MULU 0xFF*0xFF
        @(negedge clk);
        op8 = 4'd12; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (out_valid8) seen = 1;
        end
        check("w8.mulu.latency", 64'(n), 64'd9);
        check("w8.mulu.prod", 64'({result_hi8, result8}), 64'hFE01);
        check("w8.mulu.cf", 64'(cfout8), 64'd1);
        $display("w8 mulu ff*ff -> %h%h lat=%0d", result_hi8, result8, n);

        // WIDTH=8 instance: SHL 0x81 by 1
        @(negedge clk);
        op8 = 4'd7; a8 = 8'h81; b8 = 8'h01; cfin8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        @(negedge clk);
        check("w8.shl.valid", 64'(out_valid8), 64'd1);
        check("w8.shl.result", 64'(result8), 64'h02);
        check("w8.shl.cf", 64'(cfout8), 64'd1);
        $display("w8 shl 81<<1 -> r=%h cf=%0d", result8, cfout8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
